// File: rtl/adma_pkg.sv
// Shared types and descriptor field positions for the ADMA engine.
package adma_pkg;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_FDS,
    ST_CADR,
    ST_TFR,
    ST_GAP
  } state_t;

  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSV  = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  localparam int VALID_B  = 0;
  localparam int END_B    = 1;
  localparam int ACT_LSB  = 4;
  localparam int LEN_LSB  = 16;
  localparam int ADDR_LSB = 32;

endpackage

// File: rtl/adma_desc_decode.sv
// Splits a raw descriptor word into its fields; purely combinational.
module adma_desc_decode
  import adma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic [ADDR_W+31:0] desc_i,
  output logic               valid_o,
  output logic               end_o,
  output logic [1:0]         act_o,
  output logic [LEN_W-1:0]   len_o,
  output logic [ADDR_W-1:0]  addr_o
);

  assign valid_o = desc_i[VALID_B];
  assign end_o   = desc_i[END_B];
  assign act_o   = desc_i[ACT_LSB +: 2];
  assign len_o   = desc_i[LEN_LSB +: LEN_W];
  assign addr_o  = desc_i[ADDR_LSB +: ADDR_W];

  // Reserved bits are carried in the word but carry no meaning here.
  logic unused_bits;
  if (LEN_W < 16) begin : g_pad
    assign unused_bits = ^{desc_i[ACT_LSB-1:END_B+1], desc_i[LEN_LSB-1:ACT_LSB+2],
                           desc_i[ADDR_LSB-1:LEN_LSB+LEN_W]};
  end else begin : g_nopad
    assign unused_bits = ^{desc_i[ACT_LSB-1:END_B+1], desc_i[LEN_LSB-1:ACT_LSB+2]};
  end

endmodule

// File: rtl/adma_engine.sv
// ADMA2-style descriptor engine: walks a descriptor chain and moves beats
// between RAM and the SD data FIFO in either direction, with block gaps.
module adma_engine
  import adma_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int BLK_W  = 12,
  parameter int DESC_W = ADDR_W + 32
) (
  input  logic              clk_in_COM,
  input  logic              reset_in_COM,
  input  logic              start,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic              write_in_COM,
  input  logic              error_in_COM,
  input  logic [BLK_W-1:0]  block_size_REG,
  input  logic              stop_block_gap_REG,
  input  logic              continue_block_gap_REG,
  output logic              desc_req,
  output logic [ADDR_W-1:0] desc_addr,
  input  logic              desc_ack,
  input  logic [DESC_W-1:0] desc_in,
  output logic [ADDR_W-1:0] addr_out_RAM,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] data_in_RAM,
  output logic [DATA_W-1:0] data_out_RAM,
  output logic              fifo_push,
  output logic [DATA_W-1:0] data_out_FIFO,
  input  logic              full_FIFO,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] data_in_FIFO,
  input  logic              empty_FIFO,
  output logic              busy,
  output logic              transfer_complete,
  output logic              adma_error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] DESC_STEP = ADDR_W'(DESC_W / 8);
  localparam logic [LEN_W:0]    CNT_ONE   = (LEN_W+1)'(1);
  localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   desc_addr_q, desc_addr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [LEN_W:0]      beat_cnt_q, beat_cnt_d;   // one extra bit holds 2^LEN_W
  logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic                dir_q, dir_d;
  logic                end_q, end_d;
  logic                gap_req_q, gap_req_d;     // boundary hit, gap once drained
  logic                gap_cadr_q, gap_cadr_d;   // gap coincided with descriptor end
  logic                rd_pend_q, rd_pend_d;     // RAM read returns this cycle
  logic                hold_vld_q, hold_vld_d;   // returned word parked by full FIFO
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                rd_fire, wr_fire, push, abort;

  logic                d_valid, d_end;
  logic [1:0]          d_act;
  logic [LEN_W-1:0]    d_len;
  logic [ADDR_W-1:0]   d_addr;

  adma_desc_decode #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dec (
    .desc_i  (desc_in),
    .valid_o (d_valid),
    .end_o   (d_end),
    .act_o   (d_act),
    .len_o   (d_len),
    .addr_o  (d_addr)
  );

  // Next-state, beat strobes, block counting and abort handling.
  always_comb begin
    state_d     = state_q;
    desc_addr_d = desc_addr_q;
    ram_addr_d  = ram_addr_q;
    err_addr_d  = err_addr_q;
    beat_cnt_d  = beat_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    dir_d       = dir_q;
    end_d       = end_q;
    gap_req_d   = gap_req_q;
    gap_cadr_d  = gap_cadr_q;
    hold_vld_d  = hold_vld_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    abort       = 1'b0;
    rd_fire     = 1'b0;
    wr_fire     = 1'b0;
    push        = 1'b0;

    if (state_q == ST_TFR && !error_in_COM) begin
      if (dir_q) begin
        push    = (rd_pend_q | hold_vld_q) & ~full_FIFO;
        rd_fire = ~full_FIFO & ~hold_vld_q & ~gap_req_q & (beat_cnt_q != '0);
      end else begin
        wr_fire = ~empty_FIFO & ~gap_req_q & (beat_cnt_q != '0);
      end
    end
    rd_pend_d = rd_fire;

    // A returning word that cannot be pushed is parked until the FIFO drains.
    if (rd_pend_q && !push) begin
      hold_vld_d = 1'b1;
      hold_d     = data_in_RAM;
    end else if (hold_vld_q && push) begin
      hold_vld_d = 1'b0;
    end

    if (rd_fire || wr_fire) begin
      ram_addr_d = ram_addr_q + BEAT_STEP;
      beat_cnt_d = beat_cnt_q - CNT_ONE;
      if (block_size_REG != '0) begin
        if (blk_cnt_q + BLK_ONE == block_size_REG) begin
          blk_cnt_d = '0;
          if (stop_block_gap_REG) gap_req_d = 1'b1;
        end else begin
          blk_cnt_d = blk_cnt_q + BLK_ONE;
        end
      end
    end

    unique case (state_q)
      ST_STOP: begin
        if (start) begin
          state_d     = ST_FDS;
          desc_addr_d = desc_base;
          dir_d       = write_in_COM;
          err_addr_d  = '0;
          blk_cnt_d   = '0;
          gap_req_d   = 1'b0;
        end
      end
      ST_FDS: begin
        if (desc_ack) begin
          if (!d_valid) begin
            abort = 1'b1;
          end else if (d_act == ACT_LINK) begin
            desc_addr_d = d_addr;          // end bit on a link is ignored
          end else if (d_act == ACT_TRAN) begin
            state_d    = ST_TFR;
            end_d      = d_end;
            ram_addr_d = d_addr;
            beat_cnt_d = (d_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, d_len};
          end else begin
            state_d = ST_CADR;
            end_d   = d_end;
          end
        end
      end
      ST_CADR: begin
        if (end_q) begin
          state_d = ST_STOP;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_FDS;
          desc_addr_d = desc_addr_q + DESC_STEP;
        end
      end
      ST_TFR: begin
        // Leave only once no read is in flight and nothing is parked.
        if ((gap_req_d || beat_cnt_d == '0) && !rd_fire && !hold_vld_d) begin
          if (gap_req_d) begin
            state_d    = ST_GAP;
            gap_req_d  = 1'b0;
            gap_cadr_d = (beat_cnt_d == '0);
          end else begin
            state_d = ST_CADR;
          end
        end
      end
      ST_GAP: begin
        if (continue_block_gap_REG) state_d = gap_cadr_q ? ST_CADR : ST_TFR;
      end
      default: state_d = ST_STOP;
    endcase

    if (abort || (error_in_COM && state_q != ST_STOP)) begin
      state_d    = ST_STOP;
      err_d      = 1'b1;
      err_addr_d = desc_addr_q;
      rd_pend_d  = 1'b0;
      hold_vld_d = 1'b0;
      gap_req_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in_COM) begin
    if (reset_in_COM) begin
      state_q     <= ST_STOP;
      desc_addr_q <= '0;
      ram_addr_q  <= '0;
      err_addr_q  <= '0;
      beat_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      dir_q       <= 1'b0;
      end_q       <= 1'b0;
      gap_req_q   <= 1'b0;
      gap_cadr_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_addr_q <= desc_addr_d;
      ram_addr_q  <= ram_addr_d;
      err_addr_q  <= err_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      dir_q       <= dir_d;
      end_q       <= end_d;
      gap_req_q   <= gap_req_d;
      gap_cadr_q  <= gap_cadr_d;
      rd_pend_q   <= rd_pend_d;
      hold_vld_q  <= hold_vld_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign desc_req          = (state_q == ST_FDS) && !error_in_COM;
  assign desc_addr         = desc_addr_q;
  assign addr_out_RAM      = ram_addr_q;
  assign ram_rd            = rd_fire;
  assign ram_wr            = wr_fire;
  assign fifo_pop          = wr_fire;
  assign data_out_RAM      = wr_fire ? data_in_FIFO : '0;
  assign fifo_push         = push;
  assign data_out_FIFO     = push ? (hold_vld_q ? hold_q : data_in_RAM) : '0;
  assign busy              = (state_q != ST_STOP);
  assign transfer_complete = done_q;
  assign adma_error        = err_q;
  assign err_addr          = err_addr_q;

endmodule

// File: tb/tb_adma_engine.sv
// Scoreboard bench for adma_engine: stimulus queues expected events, a
// negedge monitor pops and compares them as the DUT produces them.
module tb_adma_engine;

  localparam int ADDR_W = 64, DATA_W = 8, LEN_W = 16, BLK_W = 12, DESC_W = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, start = 1'b0, write_in = 1'b0, err_in = 1'b0;
  logic [ADDR_W-1:0] desc_base = '0;
  logic [BLK_W-1:0]  blk_size = '0;
  logic              stop_gap = 1'b0, cont_gap = 1'b0, full_FIFO = 1'b0;
  logic              desc_req, desc_ack = 1'b0;
  logic [ADDR_W-1:0] desc_addr, addr_out_RAM, err_addr;
  logic [DESC_W-1:0] desc_in = '0;
  logic              ram_rd, ram_wr, fifo_push, fifo_pop, empty_FIFO;
  logic [DATA_W-1:0] data_in_RAM = '0, data_out_RAM, data_out_FIFO, data_in_FIFO;
  logic              busy, transfer_complete, adma_error;

  adma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .BLK_W(BLK_W),
                .DESC_W(DESC_W)) dut (
    .clk_in_COM(clk), .reset_in_COM(rst), .start(start), .desc_base(desc_base),
    .write_in_COM(write_in), .error_in_COM(err_in), .block_size_REG(blk_size),
    .stop_block_gap_REG(stop_gap), .continue_block_gap_REG(cont_gap),
    .desc_req(desc_req), .desc_addr(desc_addr), .desc_ack(desc_ack), .desc_in(desc_in),
    .addr_out_RAM(addr_out_RAM), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .data_in_RAM(data_in_RAM), .data_out_RAM(data_out_RAM),
    .fifo_push(fifo_push), .data_out_FIFO(data_out_FIFO), .full_FIFO(full_FIFO),
    .fifo_pop(fifo_pop), .data_in_FIFO(data_in_FIFO), .empty_FIFO(empty_FIFO),
    .busy(busy), .transfer_complete(transfer_complete), .adma_error(adma_error),
    .err_addr(err_addr));

  int errors = 0, checks = 0;
  int cyc = 0, last_beat = 0;
  int rd_seen = 0, push_seen = 0, wr_seen = 0, done_seen = 0, done_exp = 0;
  logic lat_chk = 1'b1;

  logic [ADDR_W-1:0] exp_desc[$], exp_rd[$], exp_err[$];
  logic [DATA_W-1:0] exp_push[$];
  logic [71:0]       exp_wr[$];
  logic [DESC_W-1:0] dmem [logic [63:0]];

  logic [7:0] fifo_mem [32];
  int         rd_ptr = 0, wr_cnt = 0;
  assign data_in_FIFO = fifo_mem[rd_ptr[4:0]];
  assign empty_FIFO   = (rd_ptr == wr_cnt);

  function automatic logic [7:0] rf(input logic [63:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [95:0] mk(input logic v, input logic e, input logic [1:0] act,
                                     input logic [15:0] len, input logic [63:0] a);
    return {a, len, 10'b0, act, 2'b00, e, v};
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm, input logic [71:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value %0h", nm, act);
  endtask

  // RAM read port and FIFO read side, modelled as registers.
  always @(posedge clk) begin
    if (ram_rd) data_in_RAM <= rf(addr_out_RAM);
    if (fifo_pop) rd_ptr <= rd_ptr + 1;
  end

  // Descriptor memory answers in the requesting cycle; then the scoreboard.
  always @(negedge clk) begin
    cyc++;
    desc_ack = desc_req;
    desc_in  = (desc_req && dmem.exists(desc_addr)) ? dmem[desc_addr] : '0;
    if (desc_req) begin
      if (exp_desc.size() == 0) miss("desc_fetch", desc_addr);
      else chk("desc_fetch", desc_addr, exp_desc.pop_front());
    end
    if (ram_rd) begin
      rd_seen++;
      chk("rd_while_full", full_FIFO, 0);
      if (exp_rd.size() == 0) miss("ram_rd", addr_out_RAM);
      else chk("ram_rd_addr", addr_out_RAM, exp_rd.pop_front());
    end
    if (fifo_push) begin
      push_seen++;
      last_beat = cyc;
      if (exp_push.size() == 0) miss("fifo_push", data_out_FIFO);
      else chk("fifo_push_data", data_out_FIFO, exp_push.pop_front());
    end
    if (ram_wr) begin
      wr_seen++;
      last_beat = cyc;
      if (exp_wr.size() == 0) miss("ram_wr", {addr_out_RAM, data_out_RAM});
      else chk("ram_wr_addr_data", {addr_out_RAM, data_out_RAM}, exp_wr.pop_front());
    end
    if (transfer_complete) begin
      done_seen++;
      chk("busy_at_complete", busy, 0);
      if (lat_chk) chk("complete_latency", cyc - last_beat, 2);
    end
    if (adma_error) begin
      if (exp_err.size() == 0) miss("adma_error", err_addr);
      else chk("err_addr", err_addr, exp_err.pop_front());
    end
  end

  task automatic go(input logic [63:0] base, input logic dir);
    @(negedge clk);
    desc_base = base;
    write_in  = dir;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("desc_req_after_start", desc_req, 1);
  endtask

  task automatic drain(input string nm);
    int n;
    logic ok;
    n = 0;
    repeat (2) @(posedge clk);
    while ((busy || exp_desc.size() != 0 || exp_rd.size() != 0 || exp_push.size() != 0 ||
            exp_wr.size() != 0 || exp_err.size() != 0 || done_seen != done_exp) && n < 400) begin
      @(posedge clk);
      n++;
    end
    ok = !busy && exp_desc.size() == 0 && exp_rd.size() == 0 && exp_push.size() == 0 &&
         exp_wr.size() == 0 && exp_err.size() == 0 && done_seen == done_exp;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: busy=%0d left desc=%0d rd=%0d push=%0d wr=%0d err=%0d done=%0d/%0d",
               nm, busy, exp_desc.size(), exp_rd.size(), exp_push.size(), exp_wr.size(),
               exp_err.size(), done_seen, done_exp);
    end
  endtask

  task automatic wait_until(input string nm, input int target, input int which);
    int n;
    int v;
    n = 0;
    v = (which == 0) ? rd_seen : (which == 1) ? push_seen : wr_seen;
    while (v < target && n < 200) begin
      @(posedge clk);
      n++;
      v = (which == 0) ? rd_seen : (which == 1) ? push_seen : wr_seen;
    end
    if (v < target) miss({nm, "_timeout"}, v);
  endtask

  task automatic load_fifo(input logic [7:0] b);
    fifo_mem[wr_cnt[4:0]] = b;
    wr_cnt++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_addrs", {desc_addr | addr_out_RAM | err_addr}, 0);
    chk("reset_strobes", {desc_req, ram_rd, ram_wr, fifo_push, fifo_pop,
                          transfer_complete, adma_error}, 0);
    chk("reset_data", {data_out_RAM, data_out_FIFO}, 0);
    rst = 1'b0;

    // Single descriptor, RAM -> FIFO, 4 beats at 0x1000.
    dmem[64'h40] = mk(1, 1, 2'b10, 16'd4, 64'h1000);
    exp_desc.push_back(64'h40);
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(64'h1000 + 64'(i));
      exp_push.push_back(rf(64'h1000 + 64'(i)));
    end
    done_exp++;
    go(64'h40, 1'b1);
    drain("single");

    // tran 2, link (end bit set, ignored), tran 3 end; FIFO -> RAM.
    dmem[64'h100] = mk(1, 0, 2'b10, 16'd2, 64'h4000);
    dmem[64'h10C] = mk(1, 1, 2'b11, 16'd0, 64'h800);
    dmem[64'h800] = mk(1, 1, 2'b10, 16'd3, 64'h2000);
    exp_desc.push_back(64'h100); exp_desc.push_back(64'h10C); exp_desc.push_back(64'h800);
    load_fifo(8'h11); load_fifo(8'h22); load_fifo(8'h33); load_fifo(8'h44); load_fifo(8'h55);
    exp_wr.push_back({64'h4000, 8'h11}); exp_wr.push_back({64'h4001, 8'h22});
    exp_wr.push_back({64'h2000, 8'h33}); exp_wr.push_back({64'h2001, 8'h44});
    exp_wr.push_back({64'h2002, 8'h55});
    done_exp++;
    go(64'h100, 1'b0);
    drain("chain");

    // Block gaps: size 4, length 8, stop held; second gap lands on the end.
    blk_size = 12'd4;
    stop_gap = 1'b1;
    lat_chk  = 1'b0;
    dmem[64'h300] = mk(1, 1, 2'b10, 16'd8, 64'h5000);
    exp_desc.push_back(64'h300);
    for (int i = 0; i < 8; i++) begin
      load_fifo(8'hA0 + 8'(i));
      exp_wr.push_back({64'h5000 + 64'(i), 8'hA0 + 8'(i)});
    end
    done_exp++;
    base = wr_seen;
    go(64'h300, 1'b0);
    wait_until("gap1", base + 4, 2);
    repeat (10) @(posedge clk);
    chk("gap1_beats", wr_seen - base, 4);
    chk("gap1_busy", busy, 1);
    @(negedge clk); cont_gap = 1'b1;
    @(negedge clk); cont_gap = 1'b0;
    wait_until("gap2", base + 8, 2);
    repeat (5) @(posedge clk);
    chk("gap2_beats", wr_seen - base, 8);
    chk("gap2_busy", busy, 1);
    chk("gap2_no_complete", done_seen, done_exp - 1);
    @(negedge clk); cont_gap = 1'b1;
    @(negedge clk); cont_gap = 1'b0;
    drain("gap");
    stop_gap = 1'b0;
    blk_size = '0;
    lat_chk  = 1'b1;

    // FIFO full for 3 cycles mid-transfer; a start while busy is ignored.
    dmem[64'h400] = mk(1, 1, 2'b10, 16'd8, 64'h6000);
    exp_desc.push_back(64'h400);
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back(64'h6000 + 64'(i));
      exp_push.push_back(rf(64'h6000 + 64'(i)));
    end
    done_exp++;
    base = push_seen;
    go(64'h400, 1'b1);
    wait_until("stall", base + 3, 1);
    #1 full_FIFO = 1'b1; start = 1'b1; desc_base = 64'h999;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 full_FIFO = 1'b0;
    drain("stall");

    // Second descriptor invalid: error at its address, no transfer from it.
    dmem[64'h200] = mk(1, 0, 2'b10, 16'd1, 64'h7000);
    dmem[64'h20C] = mk(0, 0, 2'b10, 16'd5, 64'h7100);
    exp_desc.push_back(64'h200); exp_desc.push_back(64'h20C);
    exp_rd.push_back(64'h7000);
    exp_push.push_back(rf(64'h7000));
    exp_err.push_back(64'h20C);
    go(64'h200, 1'b1);
    drain("invalid");
    chk("err_addr_held", err_addr, 64'h20C);

    // External abort while the third read is in flight: its word is dropped.
    dmem[64'h500] = mk(1, 1, 2'b10, 16'd8, 64'h8000);
    exp_desc.push_back(64'h500);
    for (int i = 0; i < 3; i++) exp_rd.push_back(64'h8000 + 64'(i));
    exp_push.push_back(rf(64'h8000)); exp_push.push_back(rf(64'h8001));
    exp_err.push_back(64'h500);
    base = rd_seen;
    go(64'h500, 1'b1);
    wait_until("abort", base + 3, 0);
    #1 err_in = 1'b1;
    @(posedge clk); #1 err_in = 1'b0;
    drain("abort");

    // Fresh start after the abort.
    dmem[64'h600] = mk(1, 1, 2'b10, 16'd2, 64'h9000);
    exp_desc.push_back(64'h600);
    exp_rd.push_back(64'h9000); exp_rd.push_back(64'h9001);
    exp_push.push_back(rf(64'h9000)); exp_push.push_back(rf(64'h9001));
    done_exp++;
    go(64'h600, 1'b1);
    drain("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
